// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: instruction packet layout and fetch error cause codes.
package fetch_queue_pkg;

    localparam int FQ_PKT_W = 81;

    localparam int FQ_BPTAKEN  = 0;
    localparam int FQ_BPTAG_LO = 1;
    localparam int FQ_BPTAG_HI = 16;
    localparam int FQ_INSN_LO  = 17;
    localparam int FQ_INSN_HI  = 48;
    localparam int FQ_ADDR_LO  = 49;
    localparam int FQ_ADDR_HI  = 79;
    localparam int FQ_ERR      = 80;

    // Cause codes carried alongside fetch_*_error so fetch and decode agree.
    localparam logic [3:0] ERR_IALIGN = 4'd0;
    localparam logic [3:0] ERR_IFAULT = 4'd1;

    function automatic logic [FQ_PKT_W-1:0] fq_pack(
        input logic        error,
        input logic [30:0] addr,
        input logic [31:0] insn,
        input logic [15:0] bptag,
        input logic        bptaken
    );
        logic [FQ_PKT_W-1:0] pkt;
        pkt = '0;
        pkt[FQ_ERR]                    = error;
        pkt[FQ_ADDR_HI:FQ_ADDR_LO]     = addr;
        pkt[FQ_INSN_HI:FQ_INSN_LO]     = insn;
        pkt[FQ_BPTAG_HI:FQ_BPTAG_LO]   = bptag;
        pkt[FQ_BPTAKEN]                = bptaken;
        return pkt;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Packet storage for fetch_queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [FQ_PKT_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [FQ_PKT_W-1:0] rdata
);

    logic [FQ_PKT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer with flush. Optional macro FETCHQ_BYPASS_EN lets a packet
// pass straight through an empty queue to a ready decoder in the same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_fq_valid,
    input  logic          fetch_fq_error,
    input  logic [30:0]   fetch_fq_addr,
    input  logic [31:0]   fetch_fq_insn,
    input  logic [15:0]   fetch_fq_bptag,
    input  logic          fetch_fq_bptaken,
    output logic          fq_stall,
    output logic          fetch_de_valid,
    output logic          fetch_de_error,
    output logic [30:0]   fetch_de_addr,
    output logic [31:0]   fetch_de_insn,
    output logic [15:0]   fetch_de_bptag,
    output logic          fetch_de_bptaken,
    input  logic          decode_stall,
    input  logic          rob_flush,
    output logic [AW:0]   fq_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]       hd;
    logic [AW-1:0]       tl;
    logic [AW:0]         cnt;
    logic                empty;
    logic                push;
    logic                pop;
    logic                bypass;
    logic [FQ_PKT_W-1:0] wr_pkt;
    logic [FQ_PKT_W-1:0] rd_pkt;
    logic [FQ_PKT_W-1:0] out_pkt;

    assign wr_pkt   = fq_pack(fetch_fq_error, fetch_fq_addr, fetch_fq_insn,
                              fetch_fq_bptag, fetch_fq_bptaken);
    assign empty    = (cnt == '0);
    assign fq_stall = (cnt == FULL_CNT);
    assign fq_count = cnt;

`ifdef FETCHQ_BYPASS_EN
    // A bypassed packet is consumed by decode directly and never occupies an entry.
    assign bypass         = empty & fetch_fq_valid & ~decode_stall & ~rob_flush;
    assign fetch_de_valid = ~rob_flush & (~empty | bypass);
    assign out_pkt        = bypass ? wr_pkt : rd_pkt;
`else
    assign bypass         = 1'b0;
    assign fetch_de_valid = ~empty;
    assign out_pkt        = rd_pkt;
`endif

    assign push = fetch_fq_valid & ~fq_stall & ~bypass;
    assign pop  = ~empty & ~decode_stall;

    assign fetch_de_error   = out_pkt[FQ_ERR];
    assign fetch_de_addr    = out_pkt[FQ_ADDR_HI:FQ_ADDR_LO];
    assign fetch_de_insn    = out_pkt[FQ_INSN_HI:FQ_INSN_LO];
    assign fetch_de_bptag   = out_pkt[FQ_BPTAG_HI:FQ_BPTAG_LO];
    assign fetch_de_bptaken = out_pkt[FQ_BPTAKEN];

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (tl),
        .wdata (wr_pkt),
        .raddr (hd),
        .rdata (rd_pkt)
    );

    // Flush drops any same-cycle push or pop; a write into the array is harmless since tl resets.
    always_ff @(posedge clk) begin
        if (rst || rob_flush) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                tl <= tl + AW'(1);
            end
            if (pop) begin
                hd <= hd + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed fill/wrap/flush/reset scenarios plus random traffic.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_fq_valid;
    logic        fetch_fq_error;
    logic [30:0] fetch_fq_addr;
    logic [31:0] fetch_fq_insn;
    logic [15:0] fetch_fq_bptag;
    logic        fetch_fq_bptaken;
    logic        fq_stall;
    logic        fetch_de_valid;
    logic        fetch_de_error;
    logic [30:0] fetch_de_addr;
    logic [31:0] fetch_de_insn;
    logic [15:0] fetch_de_bptag;
    logic        fetch_de_bptaken;
    logic        decode_stall;
    logic        rob_flush;
    logic [AW:0] fq_count;

    logic [80:0] exp_q[$];
    int          checks = 0;
    int          passed = 0;
    bit          armed  = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_fq_valid   (fetch_fq_valid),
        .fetch_fq_error   (fetch_fq_error),
        .fetch_fq_addr    (fetch_fq_addr),
        .fetch_fq_insn    (fetch_fq_insn),
        .fetch_fq_bptag   (fetch_fq_bptag),
        .fetch_fq_bptaken (fetch_fq_bptaken),
        .fq_stall         (fq_stall),
        .fetch_de_valid   (fetch_de_valid),
        .fetch_de_error   (fetch_de_error),
        .fetch_de_addr    (fetch_de_addr),
        .fetch_de_insn    (fetch_de_insn),
        .fetch_de_bptag   (fetch_de_bptag),
        .fetch_de_bptaken (fetch_de_bptaken),
        .decode_stall     (decode_stall),
        .rob_flush        (rob_flush),
        .fq_count         (fq_count)
    );

    function automatic logic [80:0] in_pkt();
        return {fetch_fq_error, fetch_fq_addr, fetch_fq_insn, fetch_fq_bptag, fetch_fq_bptaken};
    endfunction

    task automatic checkOutput(input string name, input logic [80:0] got, input logic [80:0] want);
        checks++;
        if (got === want) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs; payload fields are derived from the byte address so a held packet stays stable.
    task automatic applyStimulus(input bit v, input logic [31:0] byte_addr, input bit ds,
                                 input bit fl, input bit rs);
        @(posedge clk);
        #1;
        rst              = rs;
        rob_flush        = fl;
        decode_stall     = ds;
        fetch_fq_valid   = v;
        fetch_fq_addr    = byte_addr[31:1];
        fetch_fq_insn    = {byte_addr[15:0] ^ 16'h5A5A, ~byte_addr[15:0]};
        fetch_fq_bptag   = byte_addr[17:2];
        fetch_fq_error   = byte_addr[4];
        fetch_fq_bptaken = byte_addr[3];
    endtask

    // Reference model: the queue contents themselves; accepted pushes enqueue the expected packet.
    always @(posedge clk) begin : model_update
        bit full;
        bit byp;
        full = (exp_q.size() == DEPTH);
        byp  = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp  = (exp_q.size() == 0) && fetch_fq_valid && !decode_stall;
`endif
        if (rst || rob_flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && !decode_stall) begin
                void'(exp_q.pop_front());
            end
            if (fetch_fq_valid && !full && !byp) begin
                exp_q.push_back(in_pkt());
            end
        end
    end

    // Monitor: compare occupancy flags every cycle and the head packet whenever decode takes it.
    always @(negedge clk) begin : monitor
        bit          exp_valid;
        logic [80:0] exp_data;
        if (armed) begin
            exp_valid = (exp_q.size() != 0);
            exp_data  = (exp_q.size() != 0) ? exp_q[0] : 81'h0;
`ifdef FETCHQ_BYPASS_EN
            if (exp_q.size() == 0 && fetch_fq_valid && !decode_stall) begin
                exp_valid = 1'b1;
                exp_data  = in_pkt();
            end
            if (rob_flush) begin
                exp_valid = 1'b0;
            end
`endif
            checkOutput("count", 81'(fq_count), 81'(exp_q.size()));
            checkOutput("stall", 81'(fq_stall), 81'(exp_q.size() == DEPTH));
            checkOutput("valid", 81'(fetch_de_valid), 81'(exp_valid));
            if (exp_valid && !decode_stall) begin
                checkOutput("head_pkt",
                            {fetch_de_error, fetch_de_addr, fetch_de_insn, fetch_de_bptag, fetch_de_bptaken},
                            exp_data);
            end
        end
    end

    initial begin
        rst              = 1'b1;
        rob_flush        = 1'b0;
        decode_stall     = 1'b0;
        fetch_fq_valid   = 1'b0;
        fetch_fq_error   = 1'b0;
        fetch_fq_addr    = '0;
        fetch_fq_insn    = '0;
        fetch_fq_bptag   = '0;
        fetch_fq_bptaken = 1'b0;
        @(posedge clk);
        #1;
        armed = 1'b1;
        applyStimulus(0, 32'h0, 0, 0, 1);

        $display("[TB] fill");
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h100 + 32'(4 * i), 1, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 32'h110, 1, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 32'h110, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 0, 0, 0);

        $display("[TB] wrap");
        for (int i = 0; i < 10; i++) applyStimulus(1, 32'h300 + 32'(4 * i), i == 3, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 0, 0, 0);

        $display("[TB] simultaneous push/pop");
        applyStimulus(1, 32'h400, 1, 0, 0);
        applyStimulus(1, 32'h404, 1, 0, 0);
        applyStimulus(1, 32'h408, 0, 0, 0);
        applyStimulus(0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 0, 0);

        $display("[TB] flush");
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h500 + 32'(4 * i), 1, 0, 0);
        applyStimulus(1, 32'h50C, 1, 1, 0);
        applyStimulus(1, 32'h200, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 0, 0, 0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h600 + 32'(4 * i), 1, 0, 0);
        applyStimulus(1, 32'h60C, 0, 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, 0, 0, 0);

        $display("[TB] empty-queue latency");
        applyStimulus(1, 32'h13, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0);
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
